// File: rtl/pwm_peripheral_if.sv
// Register-block side of the PWM peripheral: configuration in, pin outputs and period marker back.
interface pwm_peripheral_if;
  logic [7:0]  EN_OUT_7_0;
  logic [7:0]  EN_OUT_15_8;
  logic [7:0]  EN_PWM_MODE_7_0;
  logic [7:0]  EN_PWM_MODE_15_8;
  logic [7:0]  PWM_DUTY_CYCLE_7_0;
  logic [15:0] PWM_OUT;
  logic        PERIOD_START;

  modport master (
    output EN_OUT_7_0, EN_OUT_15_8, EN_PWM_MODE_7_0, EN_PWM_MODE_15_8, PWM_DUTY_CYCLE_7_0,
    input  PWM_OUT, PERIOD_START
  );

  modport slave (
    input  EN_OUT_7_0, EN_OUT_15_8, EN_PWM_MODE_7_0, EN_PWM_MODE_15_8, PWM_DUTY_CYCLE_7_0,
    output PWM_OUT, PERIOD_START
  );
endinterface

// File: rtl/pwm_peripheral.sv
// 16-pin static/PWM output stage driven by one shared prescaled 8-bit PWM generator.
// Duty is shadowed and only swapped at the period boundary; enable/mode act immediately.
module pwm_peripheral #(
  parameter int CLK_DIV = 3000
) (
  input  logic           clk,
  input  logic           rst,
  pwm_peripheral_if.slave bus
);

  localparam int            PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PS_ONE  = PW'(1);

  logic [PW-1:0] prescale_cnt_q, prescale_cnt_d;
  logic [7:0]    pwm_cnt_q, pwm_cnt_d;
  logic [7:0]    duty_shadow_q, duty_shadow_d;
  logic [15:0]   pwm_out_q, pwm_out_d;
  logic          period_start_q, period_start_d;

  logic          tick;
  logic          boundary;
  logic          pwm_sig;
  logic [15:0]   en;
  logic [15:0]   mode;

  always_comb begin
    en   = {bus.EN_OUT_15_8, bus.EN_OUT_7_0};
    mode = {bus.EN_PWM_MODE_15_8, bus.EN_PWM_MODE_7_0};

    tick     = (prescale_cnt_q == PS_LAST);
    boundary = tick && (pwm_cnt_q == 8'hFF);

    prescale_cnt_d = tick ? '0 : prescale_cnt_q + PS_ONE;
    pwm_cnt_d      = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    duty_shadow_d  = boundary ? bus.PWM_DUTY_CYCLE_7_0 : duty_shadow_q;
    period_start_d = boundary;

    // 0xFF is treated as full-on so the last step of the period does not dip low.
    pwm_sig = (duty_shadow_q == 8'hFF) || (pwm_cnt_q < duty_shadow_q);

    pwm_out_d = '0;
    for (int i = 0; i < 16; i++) begin
      pwm_out_d[i] = en[i] & (mode[i] ? pwm_sig : 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale_cnt_q <= '0;
      pwm_cnt_q      <= '0;
      duty_shadow_q  <= '0;
      pwm_out_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      prescale_cnt_q <= prescale_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      duty_shadow_q  <= duty_shadow_d;
      pwm_out_q      <= pwm_out_d;
      period_start_q <= period_start_d;
    end
  end

  assign bus.PWM_OUT      = pwm_out_q;
  assign bus.PERIOD_START = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Bench for pwm_peripheral: a cycle-count model of the expected pins checked every cycle,
// plus directed scenarios with hand-computed high-time and latency expectations.
module tb_pwm_peripheral;

  localparam int CLK_DIV = 4;
  localparam int PERIOD  = 256 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pwm_peripheral_if bus();

  pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Model: time since reset as a plain cycle count; duty for a period is whatever
  // the input held on the last cycle of the previous period (0 for the first one).
  int          ct = 0;
  logic [7:0]  m_duty = 8'h00;
  logic [15:0] exp_out = 16'h0000;
  logic        exp_ps = 1'b0;
  bit          model_live = 1'b0;

  function automatic logic [15:0] expect_pins(input logic [15:0] en, input logic [15:0] mode,
                                              input int step, input logic [7:0] duty);
    logic [15:0] r;
    logic        high;
    high = (duty == 8'hFF) || (step < int'(duty));
    for (int i = 0; i < 16; i++) r[i] = en[i] ? (mode[i] ? high : 1'b1) : 1'b0;
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ct         = 0;
      m_duty     = 8'h00;
      exp_out    = 16'h0000;
      exp_ps     = 1'b0;
      model_live = 1'b1;
    end else if (model_live) begin
      exp_out = expect_pins({bus.EN_OUT_15_8, bus.EN_OUT_7_0},
                            {bus.EN_PWM_MODE_15_8, bus.EN_PWM_MODE_7_0},
                            (ct % PERIOD) / CLK_DIV, m_duty);
      exp_ps  = ((ct % PERIOD) == PERIOD - 1);
      if (exp_ps) m_duty = bus.PWM_DUTY_CYCLE_7_0;
      ct++;
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      vectors++;
      if (bus.PWM_OUT !== exp_out) begin
        miscompares++;
        $display("FAIL model_pins t=%0t got %h want %h", $time, bus.PWM_OUT, exp_out);
      end
      vectors++;
      if (bus.PERIOD_START !== exp_ps) begin
        miscompares++;
        $display("FAIL model_period_start t=%0t got %b want %b", $time, bus.PERIOD_START, exp_ps);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %0d (0x%h) want %0d (0x%h)", name, act, act, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Counts cycles up to and including the next PERIOD_START and the high cycles of pin b;
  // optionally rewrites the duty input on the cycle numbered chg_at.
  task automatic count_period(input int b, input int chg_at, input logic [7:0] chg_val,
                              output int highs, output int len);
    highs = 0;
    len   = 0;
    do begin
      @(negedge clk);
      len++;
      if (len == chg_at) bus.PWM_DUTY_CYCLE_7_0 = chg_val;
      highs += int'(bus.PWM_OUT[b]);
    end while (!bus.PERIOD_START && len < PERIOD + 50);
    if (!bus.PERIOD_START) begin
      vectors++;
      miscompares++;
      $display("FAIL period_timeout got no PERIOD_START within %0d cycles", len);
    end
  endtask

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, n;
    bus.EN_OUT_7_0         = 8'h00;
    bus.EN_OUT_15_8        = 8'h00;
    bus.EN_PWM_MODE_7_0    = 8'h00;
    bus.EN_PWM_MODE_15_8   = 8'h00;
    bus.PWM_DUTY_CYCLE_7_0 = 8'h00;

    // Reset state and static-pin latency
    do_reset();
    chk("reset_pwm_out", 32'(bus.PWM_OUT), 32'h0000);
    chk("reset_period_start", 32'(bus.PERIOD_START), 32'h0);
    bus.EN_OUT_7_0 = 8'h01;
    chk("static_same_cycle", 32'(bus.PWM_OUT), 32'h0000);
    cycles(1);
    chk("static_one_cycle_later", 32'(bus.PWM_OUT), 32'h0001);
    cycles(5);

    // Duty 0x80 after reset: first period low, then 512/1024
    bus.EN_PWM_MODE_7_0    = 8'h01;
    bus.PWM_DUTY_CYCLE_7_0 = 8'h80;
    do_reset();
    count_period(0, -1, 8'h00, h, n);
    chk("first_pulse_delay", 32'(n), 32'd1024);
    chk("first_period_highs", 32'(h), 32'd0);
    count_period(0, -1, 8'h00, h, n);
    chk("duty80_highs_a", 32'(h), 32'd512);
    chk("duty80_len_a", 32'(n), 32'd1024);
    count_period(0, -1, 8'h00, h, n);
    chk("duty80_highs_b", 32'(h), 32'd512);

    // Duty 0x00 and 0xFF, including the wrap into the next period
    bus.PWM_DUTY_CYCLE_7_0 = 8'h00;
    count_period(0, -1, 8'h00, h, n);
    chk("duty00_flush_highs", 32'(h), 32'd512);
    count_period(0, -1, 8'h00, h, n);
    chk("duty00_highs", 32'(h), 32'd0);
    bus.PWM_DUTY_CYCLE_7_0 = 8'hFF;
    count_period(0, -1, 8'h00, h, n);
    chk("dutyFF_flush_highs", 32'(h), 32'd0);
    count_period(0, -1, 8'h00, h, n);
    chk("dutyFF_highs_a", 32'(h), 32'd1024);
    count_period(0, -1, 8'h00, h, n);
    chk("dutyFF_highs_b", 32'(h), 32'd1024);

    // Mid-period duty change is deferred to the next period
    bus.PWM_DUTY_CYCLE_7_0 = 8'h40;
    count_period(0, -1, 8'h00, h, n);
    count_period(0, 400, 8'hC0, h, n);
    chk("duty40_kept_mid_change", 32'(h), 32'd256);
    count_period(0, -1, 8'h00, h, n);
    chk("dutyC0_next_period", 32'(h), 32'd768);

    // Change on the boundary edge is captured; change one cycle later waits a period
    count_period(0, 1023, 8'h10, h, n);
    chk("dutyC0_before_boundary", 32'(h), 32'd768);
    bus.PWM_DUTY_CYCLE_7_0 = 8'h20;
    count_period(0, -1, 8'h00, h, n);
    chk("boundary_capture_10", 32'(h), 32'd64);
    count_period(0, -1, 8'h00, h, n);
    chk("late_change_20", 32'(h), 32'd128);

    // Mixed static/PWM pins and mid-period enable clear
    bus.EN_OUT_7_0         = 8'hFF;
    bus.EN_OUT_15_8        = 8'hFF;
    bus.EN_PWM_MODE_7_0    = 8'h00;
    bus.EN_PWM_MODE_15_8   = 8'hFF;
    bus.PWM_DUTY_CYCLE_7_0 = 8'h80;
    count_period(8, -1, 8'h00, h, n);
    chk("pin8_duty20_highs", 32'(h), 32'd128);
    cycles(100);
    chk("mixed_high_half", 32'(bus.PWM_OUT), 32'hFFFF);
    cycles(100);
    bus.EN_OUT_15_8 = 8'h00;
    chk("en_clear_same_cycle", 32'(bus.PWM_OUT), 32'hFFFF);
    cycles(1);
    chk("en_clear_next_cycle", 32'(bus.PWM_OUT), 32'h00FF);
    bus.EN_OUT_15_8 = 8'hFF;
    cycles(499);
    chk("mixed_low_half", 32'(bus.PWM_OUT), 32'h00FF);

    // Mid-period reset with outputs high
    bus.EN_PWM_MODE_15_8 = 8'h00;
    cycles(2);
    chk("pre_reset_high", 32'(bus.PWM_OUT), 32'hFFFF);
    bus.EN_OUT_15_8        = 8'h00;
    bus.EN_OUT_7_0         = 8'h01;
    bus.EN_PWM_MODE_7_0    = 8'h01;
    bus.PWM_DUTY_CYCLE_7_0 = 8'hFF;
    do_reset();
    chk("mid_reset_pwm_out", 32'(bus.PWM_OUT), 32'h0000);
    chk("mid_reset_period_start", 32'(bus.PERIOD_START), 32'h0);
    count_period(0, -1, 8'h00, h, n);
    chk("post_reset_pulse_delay", 32'(n), 32'd1024);
    chk("post_reset_first_period_low", 32'(h), 32'd0);
    count_period(0, -1, 8'h00, h, n);
    chk("post_reset_dutyFF", 32'(h), 32'd1024);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
